// File: rtl/minisys_pkg.sv
// Shared Minisys opcode/funct constants and the execute-control bundle
// produced by the ID/EX issue stage.
package minisys_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       sftmd;
        logic       alu_src;
        logic       i_format;
        logic       jrn;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } ctrl_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/id_ex_decode.sv
// Purely combinational decoder turning a Minisys instruction into the
// control fields, register addresses and immediate used by Executs32.
import minisys_pkg::*;

module id_ex_decode #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instruction,
    output ctrl_t             ctrl,
    output logic [DATA_W-1:0] sign_extend,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        shamt,
    output logic              rt_used
);

    logic r_format;
    logic i_format;
    logic is_lw;
    logic is_sw;
    logic is_branch;
    logic is_jal;
    logic is_jr;
    logic writes_reg;

    always_comb begin
        opcode    = instruction[31:26];
        funct     = instruction[5:0];
        shamt     = instruction[10:6];
        rs        = REG_AW'(instruction[25:21]);
        rt        = REG_AW'(instruction[20:16]);

        r_format  = (opcode == OP_RTYPE);
        i_format  = (opcode[5:3] == 3'b001);
        is_lw     = (opcode == OP_LW);
        is_sw     = (opcode == OP_SW);
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jal    = (opcode == OP_JAL);
        is_jr     = r_format && (funct == FN_JR);

        rt_used   = r_format || is_branch || is_sw;

        if (is_zero_ext(opcode))
            sign_extend = {{(DATA_W-16){1'b0}}, instruction[15:0]};
        else
            sign_extend = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

        // jal links through $31; stores, branches and jumps name no destination
        rd = '0;
        if (r_format)
            rd = REG_AW'(instruction[15:11]);
        else if (i_format || is_lw)
            rd = REG_AW'(instruction[20:16]);
        else if (is_jal)
            rd = REG_AW'(31);

        writes_reg = (r_format && !is_jr) || i_format || is_lw || is_jal;

        ctrl           = '0;
        ctrl.alu_op    = {r_format || i_format, is_branch};
        ctrl.sftmd     = r_format && (funct[5:3] == 3'b000);
        ctrl.alu_src   = i_format || is_lw || is_sw;
        ctrl.i_format  = i_format;
        ctrl.jrn       = is_jr;
        ctrl.mem_read  = is_lw;
        ctrl.mem_write = is_sw;
        ctrl.reg_write = writes_reg && (rd != '0);
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register for Executs32 with load-use stall detection,
// branch flush, capture-time writeback bypass and EX/MEM, MEM/WB forwarding.
import minisys_pkg::*;

module id_ex_issue #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] id_pc_plus_4,
    input  logic [DATA_W-1:0] id_read_data_1,
    input  logic [DATA_W-1:0] id_read_data_2,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              exmem_wr_en,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_wr_en,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_read_data_1,
    output logic [DATA_W-1:0] ex_read_data_2,
    output logic [DATA_W-1:0] ex_sign_extend,
    output logic [5:0]        ex_function_opcode,
    output logic [5:0]        ex_opcode,
    output logic [1:0]        ex_alu_op,
    output logic [4:0]        ex_shamt,
    output logic              ex_sftmd,
    output logic              ex_alu_src,
    output logic              ex_i_format,
    output logic              ex_jrn,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_pc_plus_4
);

    ctrl_t             dec_ctrl;
    logic [DATA_W-1:0] dec_imm;
    logic [REG_AW-1:0] dec_rs;
    logic [REG_AW-1:0] dec_rt;
    logic [REG_AW-1:0] dec_rd;
    logic [5:0]        dec_opcode;
    logic [5:0]        dec_funct;
    logic [4:0]        dec_shamt;
    logic              dec_rt_used;

    ctrl_t             ex_ctrl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;

    logic              load_use;
    logic [DATA_W-1:0] cap_op1;
    logic [DATA_W-1:0] cap_op2;

    id_ex_decode #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_decode (
        .instruction (instruction),
        .ctrl        (dec_ctrl),
        .sign_extend (dec_imm),
        .rs          (dec_rs),
        .rt          (dec_rt),
        .rd          (dec_rd),
        .opcode      (dec_opcode),
        .funct       (dec_funct),
        .shamt       (dec_shamt),
        .rt_used     (dec_rt_used)
    );

    // A load in EX cannot feed the instruction in ID until it reaches MEM/WB
    always_comb begin
        load_use = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && id_valid &&
                   ((dec_rs == ex_rd) || (dec_rt_used && (dec_rt == ex_rd)));
        id_stall = load_use || ex_stall;

        cap_op1 = id_read_data_1;
        cap_op2 = id_read_data_2;
        if (memwb_wr_en && (memwb_rd != '0) && (memwb_rd == dec_rs))
            cap_op1 = memwb_data;
        if (memwb_wr_en && (memwb_rd != '0) && (memwb_rd == dec_rt))
            cap_op2 = memwb_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid           <= 1'b0;
            ex_ctrl            <= '0;
            ex_rs              <= '0;
            ex_rt              <= '0;
            ex_op1             <= '0;
            ex_op2             <= '0;
            ex_sign_extend     <= '0;
            ex_function_opcode <= '0;
            ex_opcode          <= '0;
            ex_shamt           <= '0;
            ex_rd              <= '0;
            ex_pc_plus_4       <= '0;
        end else if (flush || (!ex_stall && load_use)) begin
            // Bubble: data fields may linger but nothing downstream acts on them
            ex_valid          <= 1'b0;
            ex_ctrl.reg_write <= 1'b0;
            ex_ctrl.mem_read  <= 1'b0;
            ex_ctrl.mem_write <= 1'b0;
            ex_ctrl.jrn       <= 1'b0;
            ex_ctrl.alu_op    <= '0;
        end else if (!ex_stall) begin
            ex_valid           <= id_valid;
            ex_ctrl            <= dec_ctrl;
            ex_rs              <= dec_rs;
            ex_rt              <= dec_rt;
            ex_op1             <= cap_op1;
            ex_op2             <= cap_op2;
            ex_sign_extend     <= dec_imm;
            ex_function_opcode <= dec_funct;
            ex_opcode          <= dec_opcode;
            ex_shamt           <= dec_shamt;
            ex_rd              <= dec_rd;
            ex_pc_plus_4       <= id_pc_plus_4;
        end
    end

    // The younger producer (EX/MEM) takes precedence over MEM/WB
    always_comb begin
        ex_read_data_1 = ex_op1;
        if (exmem_wr_en && (exmem_rd != '0) && (exmem_rd == ex_rs))
            ex_read_data_1 = exmem_result;
        else if (memwb_wr_en && (memwb_rd != '0) && (memwb_rd == ex_rs))
            ex_read_data_1 = memwb_data;

        ex_read_data_2 = ex_op2;
        if (exmem_wr_en && (exmem_rd != '0) && (exmem_rd == ex_rt))
            ex_read_data_2 = exmem_result;
        else if (memwb_wr_en && (memwb_rd != '0) && (memwb_rd == ex_rt))
            ex_read_data_2 = memwb_data;
    end

    assign ex_alu_op    = ex_ctrl.alu_op;
    assign ex_sftmd     = ex_ctrl.sftmd;
    assign ex_alu_src   = ex_ctrl.alu_src;
    assign ex_i_format  = ex_ctrl.i_format;
    assign ex_jrn       = ex_ctrl.jrn;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_reg_write = ex_ctrl.reg_write;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: an instruction-level reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_id_ex_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] instruction;
    logic [31:0] id_pc_plus_4;
    logic [31:0] id_read_data_1;
    logic [31:0] id_read_data_2;
    logic        flush;
    logic        ex_stall;
    logic        exmem_wr_en;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_wr_en;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;

    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_read_data_1;
    logic [31:0] ex_read_data_2;
    logic [31:0] ex_sign_extend;
    logic [5:0]  ex_function_opcode;
    logic [5:0]  ex_opcode;
    logic [1:0]  ex_alu_op;
    logic [4:0]  ex_shamt;
    logic        ex_sftmd;
    logic        ex_alu_src;
    logic        ex_i_format;
    logic        ex_jrn;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc_plus_4;

    int checks = 0;
    int errors = 0;

    id_ex_issue #(.DATA_W(32), .REG_AW(5)) dut (
        .clock              (clock),
        .reset              (reset),
        .id_valid           (id_valid),
        .instruction        (instruction),
        .id_pc_plus_4       (id_pc_plus_4),
        .id_read_data_1     (id_read_data_1),
        .id_read_data_2     (id_read_data_2),
        .flush              (flush),
        .ex_stall           (ex_stall),
        .exmem_wr_en        (exmem_wr_en),
        .exmem_rd           (exmem_rd),
        .exmem_result       (exmem_result),
        .memwb_wr_en        (memwb_wr_en),
        .memwb_rd           (memwb_rd),
        .memwb_data         (memwb_data),
        .id_stall           (id_stall),
        .ex_valid           (ex_valid),
        .ex_read_data_1     (ex_read_data_1),
        .ex_read_data_2     (ex_read_data_2),
        .ex_sign_extend     (ex_sign_extend),
        .ex_function_opcode (ex_function_opcode),
        .ex_opcode          (ex_opcode),
        .ex_alu_op          (ex_alu_op),
        .ex_shamt           (ex_shamt),
        .ex_sftmd           (ex_sftmd),
        .ex_alu_src         (ex_alu_src),
        .ex_i_format        (ex_i_format),
        .ex_jrn             (ex_jrn),
        .ex_mem_read        (ex_mem_read),
        .ex_mem_write       (ex_mem_write),
        .ex_reg_write       (ex_reg_write),
        .ex_rd              (ex_rd),
        .ex_pc_plus_4       (ex_pc_plus_4)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [5:0]  fn;
        logic [5:0]  op;
        logic [4:0]  shamt;
        logic [1:0]  alu_op;
        logic        sftmd;
        logic        alu_src;
        logic        i_format;
        logic        jrn;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        rt_used;
    } mdl_t;

    mdl_t m;
    logic ready = 1'b0;

    // Reference decode written per instruction class
    function automatic mdl_t ref_decode(input logic [31:0] instr);
        mdl_t d;
        logic [5:0] op;
        logic [5:0] fn;
        d = '0;
        op = instr[31:26];
        fn = instr[5:0];
        d.op = op;
        d.fn = fn;
        d.rs = instr[25:21];
        d.rt = instr[20:16];
        d.shamt = instr[10:6];
        case (op)
            6'd0: begin
                d.alu_op = 2'b10;
                d.sftmd = (fn < 6'd8);
                d.jrn = (fn == 6'd8);
                d.rd = instr[15:11];
                d.reg_write = (fn != 6'd8);
                d.rt_used = 1'b1;
            end
            6'h23: begin
                d.alu_src = 1'b1;
                d.mem_read = 1'b1;
                d.rd = instr[20:16];
                d.reg_write = 1'b1;
            end
            6'h2b: begin
                d.alu_src = 1'b1;
                d.mem_write = 1'b1;
                d.rt_used = 1'b1;
            end
            6'd4, 6'd5: begin
                d.alu_op = 2'b01;
                d.rt_used = 1'b1;
            end
            6'd3: begin
                d.rd = 5'd31;
                d.reg_write = 1'b1;
            end
            default: begin
                if (op >= 6'd8 && op < 6'd16) begin
                    d.i_format = 1'b1;
                    d.alu_src = 1'b1;
                    d.alu_op = 2'b10;
                    d.rd = instr[20:16];
                    d.reg_write = 1'b1;
                end
            end
        endcase
        if (op >= 6'h0c && op <= 6'h0e)
            d.imm = {16'h0, instr[15:0]};
        else
            d.imm = 32'($signed(instr[15:0]));
        if (d.rd == 5'd0)
            d.reg_write = 1'b0;
        return d;
    endfunction

    function automatic logic model_load_use();
        mdl_t n;
        n = ref_decode(instruction);
        return m.valid && m.mem_read && m.rd != 0 && id_valid &&
               (n.rs == m.rd || (n.rt_used && n.rt == m.rd));
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        if (exmem_wr_en && exmem_rd != 0 && exmem_rd == r) return exmem_result;
        if (memwb_wr_en && memwb_rd != 0 && memwb_rd == r) return memwb_data;
        return v;
    endfunction

    always @(posedge clock) begin
        mdl_t n;
        logic lu;
        lu = model_load_use();
        if (reset) begin
            m = '0;
            ready = 1'b1;
        end else if (flush || (!ex_stall && lu)) begin
            m.valid = 0; m.reg_write = 0; m.mem_read = 0;
            m.mem_write = 0; m.jrn = 0; m.alu_op = 2'b00;
        end else if (!ex_stall) begin
            n = ref_decode(instruction);
            n.valid = id_valid;
            n.pc4 = id_pc_plus_4;
            n.op1 = (memwb_wr_en && memwb_rd != 0 && memwb_rd == n.rs) ? memwb_data : id_read_data_1;
            n.op2 = (memwb_wr_en && memwb_rd != 0 && memwb_rd == n.rt) ? memwb_data : id_read_data_2;
            m = n;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (ready) begin
            checkOutput("m_id_stall", 32'(id_stall), 32'(model_load_use() | ex_stall));
            checkOutput("m_valid", 32'(ex_valid), 32'(m.valid));
            checkOutput("m_rd1", ex_read_data_1, fwd(m.rs, m.op1));
            checkOutput("m_rd2", ex_read_data_2, fwd(m.rt, m.op2));
            checkOutput("m_imm", ex_sign_extend, m.imm);
            checkOutput("m_fn", 32'(ex_function_opcode), 32'(m.fn));
            checkOutput("m_op", 32'(ex_opcode), 32'(m.op));
            checkOutput("m_alu_op", 32'(ex_alu_op), 32'(m.alu_op));
            checkOutput("m_shamt", 32'(ex_shamt), 32'(m.shamt));
            checkOutput("m_ctrl", {24'h0, ex_sftmd, ex_alu_src, ex_i_format, ex_jrn,
                                   ex_mem_read, ex_mem_write, ex_reg_write, 1'b0},
                        {24'h0, m.sftmd, m.alu_src, m.i_format, m.jrn,
                         m.mem_read, m.mem_write, m.reg_write, 1'b0});
            checkOutput("m_rd", 32'(ex_rd), 32'(m.rd));
            checkOutput("m_pc4", ex_pc_plus_4, m.pc4);
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                                 input logic [31:0] rd1, input logic [31:0] rd2);
        id_valid = v;
        instruction = instr;
        id_pc_plus_4 = pc4;
        id_read_data_1 = rd1;
        id_read_data_2 = rd2;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1; id_valid = 0; instruction = 0; id_pc_plus_4 = 0;
        id_read_data_1 = 0; id_read_data_2 = 0; flush = 0; ex_stall = 0;
        exmem_wr_en = 0; exmem_rd = 0; exmem_result = 0;
        memwb_wr_en = 0; memwb_rd = 0; memwb_data = 0;
        tick(); tick();
        checkOutput("rst_valid", 32'(ex_valid), 32'h0);
        checkOutput("rst_reg_write", 32'(ex_reg_write), 32'h0);
        checkOutput("rst_pc4", ex_pc_plus_4, 32'h0);
        reset = 0;

        // addi $1,$0,0xff40
        applyStimulus(1, 32'h2001ff40, 32'h104, 32'h0, 32'h0);
        tick();
        checkOutput("addi_i_format", 32'(ex_i_format), 32'h1);
        checkOutput("addi_alu_src", 32'(ex_alu_src), 32'h1);
        checkOutput("addi_alu_op", 32'(ex_alu_op), 32'h2);
        checkOutput("addi_imm", ex_sign_extend, 32'hffffff40);
        checkOutput("addi_rd", 32'(ex_rd), 32'h1);
        checkOutput("addi_reg_write", 32'(ex_reg_write), 32'h1);

        applyStimulus(1, 32'h000218c0, 32'h108, 32'h0, 32'h2);
        tick();
        checkOutput("sll_sftmd", 32'(ex_sftmd), 32'h1);
        checkOutput("sll_shamt", 32'(ex_shamt), 32'h3);
        checkOutput("sll_rd", 32'(ex_rd), 32'h3);

        applyStimulus(1, 32'h30218000, 32'h10c, 32'h1, 32'h1);
        tick();
        checkOutput("andi_imm", ex_sign_extend, 32'h00008000);

        // lw $2,0($1) followed by dependent add $3,$2,$4
        applyStimulus(1, 32'h8c220000, 32'h110, 32'h1000, 32'h0);
        tick();
        applyStimulus(1, 32'h00441820, 32'h114, 32'h5, 32'h6);
        checkOutput("lu_stall", 32'(id_stall), 32'h1);
        tick();
        checkOutput("lu_bubble_valid", 32'(ex_valid), 32'h0);
        checkOutput("lu_bubble_writes", {30'h0, ex_reg_write, ex_mem_write}, 32'h0);
        checkOutput("lu_stall_clear", 32'(id_stall), 32'h0);
        tick();
        checkOutput("lu_add_valid", 32'(ex_valid), 32'h1);
        checkOutput("lu_add_rd", 32'(ex_rd), 32'h3);

        // add $6,$5,$7 held while both later stages write $5
        applyStimulus(1, 32'h00a73020, 32'h118, 32'haaaa, 32'hbbbb);
        tick();
        ex_stall = 1;
        exmem_wr_en = 1; exmem_rd = 5; exmem_result = 32'h11;
        memwb_wr_en = 1; memwb_rd = 5; memwb_data = 32'h22;
        #1;
        checkOutput("fwd_exmem", ex_read_data_1, 32'h11);
        exmem_wr_en = 0;
        #1;
        checkOutput("fwd_memwb", ex_read_data_1, 32'h22);
        checkOutput("fwd_rt_none", ex_read_data_2, 32'hbbbb);
        tick();
        memwb_wr_en = 0; ex_stall = 0;

        // beq flushed while execute is also stalled
        applyStimulus(1, 32'h10220004, 32'h11c, 32'h1, 32'h2);
        tick();
        checkOutput("beq_alu_op", 32'(ex_alu_op), 32'h1);
        flush = 1; ex_stall = 1;
        tick();
        checkOutput("flush_valid", 32'(ex_valid), 32'h0);
        checkOutput("flush_alu_op", 32'(ex_alu_op), 32'h0);
        checkOutput("flush_reg_write", 32'(ex_reg_write), 32'h0);
        flush = 0; ex_stall = 0;

        // add $3,$2,$4 captured while MEM/WB writes $4
        memwb_wr_en = 1; memwb_rd = 4; memwb_data = 32'h55;
        applyStimulus(1, 32'h00441820, 32'h120, 32'h77, 32'h99);
        tick();
        memwb_wr_en = 0;
        #1;
        checkOutput("bypass_rt", ex_read_data_2, 32'h55);
        checkOutput("bypass_rs_none", ex_read_data_1, 32'h77);

        // lw $2 then sw $2 (rt dependence)
        applyStimulus(1, 32'h8c220000, 32'h124, 32'h1000, 32'h0);
        tick();
        applyStimulus(1, 32'hac220004, 32'h128, 32'h1000, 32'h3);
        checkOutput("sw_lu_stall", 32'(id_stall), 32'h1);
        tick(); tick();
        checkOutput("sw_mem_write", 32'(ex_mem_write), 32'h1);

        applyStimulus(1, 32'h0c000010, 32'h12c, 32'h0, 32'h0);
        tick();
        checkOutput("jal_rd", 32'(ex_rd), 32'd31);
        checkOutput("jal_reg_write", 32'(ex_reg_write), 32'h1);
        applyStimulus(1, 32'h03e00008, 32'h130, 32'h130, 32'h0);
        tick();
        checkOutput("jr_jrn", 32'(ex_jrn), 32'h1);
        checkOutput("jr_reg_write", 32'(ex_reg_write), 32'h0);
        applyStimulus(1, 32'h20000001, 32'h134, 32'h0, 32'h0);
        tick();
        checkOutput("r0_reg_write", 32'(ex_reg_write), 32'h0);

        // reset arriving during an execute stall
        applyStimulus(1, 32'h2001ff40, 32'h200, 32'h0, 32'h0);
        tick();
        ex_stall = 1; reset = 1;
        tick();
        checkOutput("rst_stall_valid", 32'(ex_valid), 32'h0);
        checkOutput("rst_stall_imm", ex_sign_extend, 32'h0);
        checkOutput("rst_stall_pc4", ex_pc_plus_4, 32'h0);
        reset = 0; ex_stall = 0;
        applyStimulus(1, 32'h000218c0, 32'h204, 32'h0, 32'h2);
        tick();
        checkOutput("post_rst_valid", 32'(ex_valid), 32'h1);
        checkOutput("post_rst_rd", 32'(ex_rd), 32'h3);
        checkOutput("post_rst_pc4", ex_pc_plus_4, 32'h204);

        applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
